// File: rtl/gemm_act_feeder.sv
// Double-buffered activation tile feeder for the GEMM systolic array.
// Two ping-pong banks: one fills from the controller while the other streams row-skewed.
module gemm_act_feeder #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ARRAY_SIZE = 16
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 wr_en,
    input  logic [$clog2(ARRAY_SIZE)-1:0]        wr_row,
    input  logic [ARRAY_SIZE*DATA_WIDTH-1:0]     wr_data,
    input  logic                                 buf_commit,
    output logic                                 wr_ready,
    input  logic                                 array_busy,
    output logic                                 start_compute,
    output logic [ARRAY_SIZE*DATA_WIDTH-1:0]     activation_out,
    output logic                                 activation_valid,
    output logic                                 busy,
    output logic [15:0]                          tiles_done
);

    localparam int unsigned N    = ARRAY_SIZE;
    localparam int unsigned RowW = $clog2(N);
    localparam int unsigned CntW = $clog2(2 * N);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StLaunch = 2'd1;
    localparam logic [1:0] StStream = 2'd2;
    localparam logic [1:0] StWait   = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]      full_q, full_d;
    logic            wr_ptr_q, wr_ptr_d;
    logic            rd_ptr_q, rd_ptr_d;
    logic [15:0]     tiles_done_q, tiles_done_d;

    logic [N-1:0][DATA_WIDTH-1:0] bank_q [2][N];

    logic            wr_fire;
    logic            commit;
    logic            last_cnt;
    logic [CntW-1:0] col;

    assign wr_ready = ~full_q[wr_ptr_q];
    assign wr_fire  = wr_en & wr_ready;
    assign commit   = buf_commit & wr_ready;
    assign last_cnt = (cnt_q == CntW'(2 * N - 1));

    // Bank storage is deliberately left unreset; a tile is only read after it is committed.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            bank_q[wr_ptr_q][wr_row] <= wr_data;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        full_d       = full_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        tiles_done_d = tiles_done_q;

        if (commit) begin
            full_d[wr_ptr_q] = 1'b1;
            wr_ptr_d         = ~wr_ptr_q;
        end

        case (state_q)
            StIdle: begin
                if (full_q[rd_ptr_q] && !array_busy) begin
                    state_d = StLaunch;
                end
            end
            StLaunch: begin
                cnt_d   = '0;
                state_d = StStream;
            end
            StStream: begin
                cnt_d = cnt_q + CntW'(1);
                // Commit can never target rd_ptr here: that bank is full, so wr_ready is low for it.
                if (last_cnt) begin
                    full_d[rd_ptr_q] = 1'b0;
                    rd_ptr_d         = ~rd_ptr_q;
                    tiles_done_d     = tiles_done_q + 16'd1;
                    state_d          = StWait;
                end
            end
            StWait: begin
                if (!array_busy) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            full_q       <= '0;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            tiles_done_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            full_q       <= full_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            tiles_done_q <= tiles_done_d;
        end
    end

    // Row i is delayed by i cycles; positions outside the tile are padded with zero.
    always_comb begin
        activation_out = '0;
        col            = '0;
        if (state_q == StStream) begin
            for (int i = 0; i < N; i++) begin
                col = cnt_q - CntW'(i);
                if ((cnt_q >= CntW'(i)) && (col < CntW'(N))) begin
                    activation_out[i*DATA_WIDTH +: DATA_WIDTH] =
                        bank_q[rd_ptr_q][i][col[RowW-1:0]];
                end
            end
        end
    end

    assign start_compute    = (state_q == StLaunch);
    assign activation_valid = (state_q == StStream);
    assign busy             = (state_q != StIdle);
    assign tiles_done       = tiles_done_q;

endmodule

// File: tb/tb_gemm_act_feeder.sv
// Randomized bench for gemm_act_feeder against a tile-queue reference model.
// Tiles are held as plain arrays; the model tracks committed tiles and cycles since launch.
module tb_gemm_act_feeder;

    localparam int N  = 16;
    localparam int DW = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              wr_en;
    logic [3:0]        wr_row;
    logic [N*DW-1:0]   wr_data;
    logic              buf_commit;
    logic              wr_ready;
    logic              array_busy;
    logic              start_compute;
    logic [N*DW-1:0]   activation_out;
    logic              activation_valid;
    logic              busy;
    logic [15:0]       tiles_done;

    gemm_act_feeder #(
        .DATA_WIDTH (DW),
        .ARRAY_SIZE (N)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .wr_en            (wr_en),
        .wr_row           (wr_row),
        .wr_data          (wr_data),
        .buf_commit       (buf_commit),
        .wr_ready         (wr_ready),
        .array_busy       (array_busy),
        .start_compute    (start_compute),
        .activation_out   (activation_out),
        .activation_valid (activation_valid),
        .busy             (busy),
        .tiles_done       (tiles_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: tile contents, queue of committed-not-yet-freed tiles, cycles since launch.
    logic [7:0]  store [4][N][N];
    int          m_q[$];
    bit          m_active;
    int          m_k;
    logic [15:0] m_tiles;
    int          cur_slot   = 0;
    int          busy_left  = 0;
    bit          rand_busy  = 1'b0;
    bit          dir_mode   = 1'b0;

    task automatic check_eq(input string tag, input logic [N*DW-1:0] got,
                            input logic [N*DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [N*DW-1:0] row_of(input int slot, input int row);
        logic [N*DW-1:0] v;
        for (int k = 0; k < N; k++) v[k*DW +: DW] = store[slot][row][k];
        return v;
    endfunction

    function automatic logic [N*DW-1:0] rand_vec();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic fill(input int slot, input int mode);
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < N; k++) begin
                case (mode)
                    0:       store[slot][i][k] = 8'(i * 16 + k);
                    1:       store[slot][i][k] = 8'($urandom);
                    2:       store[slot][i][k] = ((i + k) % 2 == 1) ? 8'h7F : 8'h80;
                    default: store[slot][i][k] = ((i + k) % 2 == 1) ? 8'h80 : 8'h7F;
                endcase
            end
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_active = 1'b0;
        m_k      = 0;
        m_tiles  = '0;
    endtask

    task automatic model_update(input logic cm, input logic bz);
        int qs;
        qs = m_q.size();
        if (!m_active) begin
            if (qs > 0 && !bz) begin
                m_active = 1'b1;
                m_k      = 0;
            end
        end else if (m_k <= 2 * N) begin
            if (m_k == 2 * N) begin
                m_q.delete(0);
                m_tiles = m_tiles + 16'd1;
            end
            m_k++;
        end else if (!bz) begin
            m_active = 1'b0;
        end
        if (cm && qs < 2) m_q.push_back(cur_slot);
    endtask

    task automatic check_outputs();
        bit              e_valid;
        logic [N*DW-1:0] e_out;
        int              c;
        e_valid = m_active && m_k >= 1 && m_k <= 2 * N;
        c       = m_k - 1;
        e_out   = '0;
        if (e_valid) begin
            for (int i = 0; i < N; i++) begin
                if (c - i >= 0 && c - i < N) e_out[i*DW +: DW] = store[m_q[0]][i][c-i];
            end
        end
        check_eq("start_compute", start_compute, m_active && m_k == 0);
        check_eq("activation_valid", activation_valid, e_valid);
        check_eq("activation_out", activation_out, e_out);
        check_eq("busy", busy, m_active);
        check_eq("wr_ready", wr_ready, m_q.size() < 2);
        check_eq("tiles_done", tiles_done, m_tiles);
        if (dir_mode && e_valid) begin
            if (c == 0) check_eq("c0_row0", activation_out[7:0], 8'h00);
            if (c == 17) begin
                check_eq("c17_row2", activation_out[23:16], 8'h2F);
                check_eq("c17_row1", activation_out[15:8], 8'h00);
            end
        end
    endtask

    // Called at a falling edge: check, drive, advance model, move to next falling edge.
    task automatic step(input logic we, input int row, input logic [N*DW-1:0] data,
                        input logic cm);
        logic bz;
        check_outputs();
        bz = (busy_left > 0);
        if (busy_left > 0) busy_left--;
        if (rand_busy && m_active && m_k == 0) busy_left = $urandom_range(10, 60);
        wr_en      = we;
        wr_row     = 4'(row);
        wr_data    = data;
        buf_commit = cm;
        array_busy = bz;
        if (rst_n) model_update(cm, bz);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic write_tile(input int slot);
        int order[N];
        int guard;
        int row;
        int tmp;
        int j;
        cur_slot = slot;
        guard    = 0;
        for (int i = 0; i < N; i++) order[i] = i;
        for (int i = N - 1; i > 0; i--) begin
            j        = $urandom_range(0, i);
            tmp      = order[i];
            order[i] = order[j];
            order[j] = tmp;
        end
        // First write garbage into the last row so the final write must overwrite it.
        for (int r = -1; r < N; r++) begin
            row = (r < 0) ? order[N-1] : order[r];
            while (m_q.size() >= 2 && guard <= 3000) begin
                step(1'b1, $urandom_range(0, N - 1), rand_vec(), $urandom_range(0, 3) == 0);
                guard++;
            end
            if (guard > 3000) begin
                check_eq("ready_wait_timeout", guard, 0);
                return;
            end
            step(1'b1, row, (r < 0) ? ~row_of(slot, row) : row_of(slot, row), r == N - 1);
        end
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((m_q.size() > 0 || m_active) && guard <= 3000) begin
            step(1'b0, 0, '0, 1'b0);
            guard++;
        end
        if (guard > 3000) check_eq("drain_timeout", guard, 0);
        repeat (2) step(1'b0, 0, '0, 1'b0);
    endtask

    initial begin
        int guard;
        rst_n      = 1'b0;
        wr_en      = 1'b0;
        wr_row     = '0;
        wr_data    = '0;
        buf_commit = 1'b0;
        array_busy = 1'b0;
        model_reset();
        @(negedge clk);
        repeat (3) step(1'b0, 0, '0, 1'b0);
        rst_n = 1'b1;

        // Single directed tile, array never busy.
        dir_mode = 1'b1;
        fill(0, 0);
        write_tile(0);
        drain();
        dir_mode = 1'b0;
        check_eq("tiles_after_single", tiles_done, 16'd1);

        // Back-to-back random tiles with a busy array model.
        rand_busy = 1'b1;
        for (int t = 0; t < 10; t++) begin
            fill((t + 1) % 4, 1);
            write_tile((t + 1) % 4);
        end
        drain();
        rand_busy = 1'b0;

        // Extreme signed patterns.
        fill(3, 2);
        write_tile(3);
        fill(0, 3);
        write_tile(0);
        drain();

        // Busy held high while a bank is full.
        busy_left = 70;
        fill(1, 1);
        write_tile(1);
        drain();

        // Reset in the middle of a stream.
        fill(2, 1);
        write_tile(2);
        guard = 0;
        while (!(m_active && m_k == 6) && guard < 200) begin
            step(1'b0, 0, '0, 1'b0);
            guard++;
        end
        check_eq("reached_mid_stream", activation_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        check_eq("rst_valid", activation_valid, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_wr_ready", wr_ready, 1'b1);
        check_eq("rst_out", activation_out, '0);
        model_reset();
        busy_left = 0;
        @(negedge clk);
        repeat (2) step(1'b0, 0, '0, 1'b0);
        rst_n = 1'b1;
        fill(3, 1);
        write_tile(3);
        drain();
        check_eq("tiles_after_reset", tiles_done, 16'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1);
    end

endmodule
